// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight register writers between
// decode and writeback, raises a stall on a read-after-write hazard, and
// generates a fixed-length flush window after each taken branch or jump.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no branch penalty outstanding, flush low
//   FLUSH | squashing fetch/decode, cnt = flush cycles still to go
module hazard_ctrl #(
  parameter int REG_W  = 3,
  parameter int DEPTH  = 2,
  parameter int BR_PEN = 2,
  parameter int FWD_EN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             branch_I,
  input  logic             branch_J,
  output logic             stall,
  output logic             flush,
  output logic [DEPTH-1:0] match_vec,
  output logic [15:0]      stall_cnt
);

  localparam int CW = $clog2(BR_PEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] slot_v_q, slot_v_d;
  logic [DEPTH-1:0] slot_ld_q, slot_ld_d;
  logic [REG_W-1:0] slot_reg_q [DEPTH];
  logic [REG_W-1:0] slot_reg_d [DEPTH];
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             raw_hazard;
  logic             branch;

  assign branch    = branch_I | branch_J;
  assign flush     = (state_q == FLUSH);
  assign stall     = raw_hazard & ~flush;
  assign stall_cnt = stall_cnt_q;

  // Compare decode sources against every tracked writer slot.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = id_valid & slot_v_q[i] &
                     ((id_rs1_used & (id_rs1 == slot_reg_q[i])) |
                      (id_rs2_used & (id_rs2 == slot_reg_q[i])));
    end
  end

  // With forwarding only a load in the youngest slot is unresolvable.
  always_comb begin
    raw_hazard = 1'b0;
    if (FWD_EN != 0) begin
      raw_hazard = match_vec[0] & slot_ld_q[0];
    end else begin
      raw_hazard = |match_vec;
    end
  end

  // Scoreboard shift: new writer enters slot 0 only when it really issues.
  always_comb begin
    slot_v_d     = '0;
    slot_ld_d    = '0;
    slot_v_d[0]  = id_valid & id_wr_en & ~stall & ~flush;
    slot_ld_d[0] = id_is_load;
    slot_reg_d[0] = id_wr_reg;
    for (int i = 1; i < DEPTH; i++) begin
      slot_v_d[i]   = slot_v_q[i-1];
      slot_ld_d[i]  = slot_ld_q[i-1];
      slot_reg_d[i] = slot_reg_q[i-1];
    end
  end

  // Branch penalty FSM: any new branch restarts the full window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (branch) begin
          state_d = FLUSH;
          cnt_d   = CW'(BR_PEN);
        end
      end
      FLUSH: begin
        if (branch) begin
          cnt_d = CW'(BR_PEN);
        end else if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers; reset empties the scoreboard and aborts any flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      slot_v_q    <= '0;
      slot_ld_q   <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_v_q    <= slot_v_d;
      slot_ld_q   <= slot_ld_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg_q[i] <= slot_reg_d[i];
      end
    end
  end

endmodule
